angle_event_sched: RTL and testbench
====================================

Name: angle_event_sched

Overview:
- Converts crank-sync tooth events into time-accurate per-channel output pulses (ignition/injection start points).
- Sits directly downstream of the crank sync block and consumes its trigger, synced, eng_phase, tooth_period and next_tooth_length_deg outputs.
- On each synced tooth it does three things:
  - derives clocks-per-angle-unit for the tooth just measured;
  - scans all channels for target angles falling inside the upcoming tooth;
  - arms per-channel countdown timers that fire one-cycle pulses.

Parameters:
NCH, 4, number of output channels (1..16)
CYCLE_DEG, 720, engine cycle length in eng_phase units; angles wrap modulo this value

Ports:
clk  input  1  system clock
reset_n  input  1  asynchronous active-low reset
trigger  input  1  one-cycle tooth pulse from sync block
synced  input  1  sync-valid level from sync block
eng_phase  input  16  phase at the current tooth, valid on trigger
tooth_period  input  32  clocks in the tooth just measured, valid on trigger
next_tooth_length_deg  input  16  angular length of the upcoming tooth, valid on trigger
ch_angle  input  16*NCH  target angle per channel; channel i uses bits [16i+15:16i]
ch_enable  input  NCH  per-channel enable
fire  output  NCH  one-cycle pulse per channel at its target angle
armed  output  NCH  channel timer currently counting
busy  output  1  FSM not in IDLE
overrun  output  1  one-cycle pulse: trigger arrived while busy

Behaviour:
- Reset: clk and reset_n as named; reset is asynchronous and active-low. All outputs, timers, prev_len and FSM clear to 0/IDLE. Reset mid-divide or mid-scan aborts silently.
- prev_len register:
  - on every trigger, prev_len <= next_tooth_length_deg;
  - the divisor used for that trigger is the old prev_len, i.e. the angular length of the tooth whose period was just measured.
- FSM states: IDLE, DIVIDE, SCAN.
- IDLE, trigger && synced:
  - latch eng_phase, tooth_period, next_tooth_length_deg (as win_len) and old prev_len (as div).
  - if div==0 or win_len==0, stay IDLE; no arming.
  - otherwise go to DIVIDE.
- DIVIDE:
  - restoring divider, tpd = tooth_period / div, unsigned, truncated, 32-bit quotient;
  - one quotient bit per cycle, exactly 32 cycles;
  - then SCAN with index 0.
- SCAN, one channel per cycle, index 0..NCH-1, then IDLE:
  - angles are valid only if < CYCLE_DEG. Channel skipped if disabled, invalid angle, or already armed.
  - offset = ch_angle - phase if ch_angle >= phase, else ch_angle + CYCLE_DEG - phase (17-bit intermediate).
  - match if offset < win_len. On match: timer <= offset*tpd (48-bit product; saturate to 32'hFFFFFFFF if bits [47:32] nonzero), and armed <= 1.
- Timers:
  - each armed timer decrements every cycle while nonzero;
  - when armed and timer==0: fire pulses for one cycle and armed clears;
  - a load value L therefore fires exactly L+1 cycles after the load cycle.
- Armed timers are unaffected by later triggers; they are cancelled only by synced low.
- synced low (any cycle, any state): all armed clear, no fire, FSM -> IDLE. Overrides any same-cycle fire.
- trigger while busy:
  - overrun pulses for one cycle;
  - the current computation aborts; channels already armed stay armed;
  - the new trigger is processed as if from IDLE, subject to the same div/win_len checks.
- trigger with synced low: prev_len still updates; no arming.
- Total latency trigger -> earliest possible arm: 33+i cycles for channel i.

Test Plan:
- Divisor and window arming: triggers with synced=1, next_tooth_length_deg=10 then 10; second trigger eng_phase=100, tooth_period=1000, ch0 angle=105 -> div=10, tpd=100, ch0 loaded 500 at cycle 33 after trigger, fire[0] 501 cycles later, armed[0] high in between.
- First-trigger skip and window exclusion: first synced trigger (prev_len=0) -> no arming, busy stays 0. Same setup as the previous scenario with ch1 angle=110 (offset=10, not <10) -> ch1 never armed.
- Wrap-around: CYCLE_DEG=720, eng_phase=715, win_len=10, ch2 angle=3 -> offset=8, loaded 8*tpd. ch3 angle=720 -> ignored.
- Saturation and zero offset:
  - tooth_period=32'hFFFFFFFF, div=1, offset=2 -> timer 32'hFFFFFFFF.
  - offset=0 -> fire exactly 1 cycle after the scan cycle.
- Overrun: second trigger 10 cycles after the first -> overrun pulse; new DIVIDE restarts; previously armed channel still fires on time.
- Sync loss and reset: synced drops with ch0 armed -> armed[0]=0, no fire. Assert reset_n mid-DIVIDE -> busy=0 and all outputs 0 immediately, asynchronously.

Source files
------------

// File: rtl/angle_event_sched.sv
// Angle-domain event scheduler: turns synced crank teeth into per-channel timed fire pulses.
//   state  | meaning
//   IDLE   | waiting for a synced tooth trigger
//   DIVIDE | restoring divide tooth_period / prev tooth length, one quotient bit per cycle
//   SCAN   | one channel per cycle: window match, load countdown timer
module angle_event_sched #(
   parameter int NCH       = 4,
   parameter int CYCLE_DEG = 720
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               trigger,
   input  logic               synced,
   input  logic [15:0]        eng_phase,
   input  logic [31:0]        tooth_period,
   input  logic [15:0]        next_tooth_length_deg,
   input  logic [16*NCH-1:0]  ch_angle,
   input  logic [NCH-1:0]     ch_enable,
   output logic [NCH-1:0]     fire,
   output logic [NCH-1:0]     armed,
   output logic               busy,
   output logic               overrun
);

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_DIVIDE = 2'd1;
   localparam logic [1:0] ST_SCAN   = 2'd2;
   localparam int              IW       = (NCH > 1) ? $clog2(NCH) : 1;
   localparam logic [IW-1:0]   LAST_IDX = IW'(NCH - 1);
   localparam logic [16:0]     CYC      = 17'(CYCLE_DEG);

   logic [1:0]            state_q, state_d;
   logic [15:0]           prev_len_q, prev_len_d;
   logic [15:0]           phase_q, phase_d;
   logic [15:0]           win_q, win_d;
   logic [15:0]           div_q, div_d;
   logic [15:0]           rem_q, rem_d;
   logic [31:0]           quo_q, quo_d;
   logic [4:0]            cnt_q, cnt_d;
   logic [IW-1:0]         idx_q, idx_d;
   logic                  overrun_q, overrun_d;
   logic [NCH-1:0][31:0]  timer_q, timer_d;
   logic [NCH-1:0]        armed_q, armed_d;
   logic [NCH-1:0]        fire_q, fire_d;

   logic [15:0]           ang_arr [NCH];
   logic [15:0]           ang;
   logic [16:0]           offset;
   logic [16:0]           rem_sh;
   logic [47:0]           prod;
   logic [31:0]           load_val;
   logic                  match;

   for (genvar g = 0; g < NCH; g++) begin : g_ang
      assign ang_arr[g] = ch_angle[16*g +: 16];
   end

   always_comb begin
      ang = ang_arr[idx_q];
      if (ang >= phase_q) offset = {1'b0, ang} - {1'b0, phase_q};
      else                offset = {1'b0, ang} + CYC - {1'b0, phase_q};
      // A trigger or sync loss in the scan cycle aborts that channel's load
      match = (state_q == ST_SCAN) && synced && !trigger && ch_enable[idx_q]
              && ({1'b0, ang} < CYC) && !armed_q[idx_q] && (offset < {1'b0, win_q});
      prod     = {32'd0, offset[15:0]} * {16'd0, quo_q};
      load_val = (|prod[47:32]) ? 32'hFFFF_FFFF : prod[31:0];
   end

   always_comb begin
      state_d    = state_q;
      phase_d    = phase_q;
      win_d      = win_q;
      div_d      = div_q;
      rem_d      = rem_q;
      quo_d      = quo_q;
      cnt_d      = cnt_q;
      idx_d      = idx_q;
      overrun_d  = trigger && (state_q != ST_IDLE);
      prev_len_d = trigger ? next_tooth_length_deg : prev_len_q;
      rem_sh     = {rem_q, quo_q[31]};
      if (!synced) begin
         state_d = ST_IDLE;
      end else if (trigger) begin
         phase_d = eng_phase;
         win_d   = next_tooth_length_deg;
         div_d   = prev_len_q;
         quo_d   = tooth_period;
         rem_d   = 16'd0;
         cnt_d   = 5'd31;
         idx_d   = '0;
         state_d = (prev_len_q == 16'd0 || next_tooth_length_deg == 16'd0) ? ST_IDLE : ST_DIVIDE;
      end else begin
         case (state_q)
            ST_DIVIDE: begin
               if (rem_sh >= {1'b0, div_q}) begin
                  rem_d = 16'(rem_sh - {1'b0, div_q});
                  quo_d = {quo_q[30:0], 1'b1};
               end else begin
                  rem_d = rem_sh[15:0];
                  quo_d = {quo_q[30:0], 1'b0};
               end
               if (cnt_q == 5'd0) begin
                  state_d = ST_SCAN;
                  idx_d   = '0;
               end else begin
                  cnt_d = cnt_q - 5'd1;
               end
            end
            ST_SCAN: begin
               if (idx_q == LAST_IDX) state_d = ST_IDLE;
               else                   idx_d   = idx_q + IW'(1);
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      timer_d = timer_q;
      armed_d = armed_q;
      fire_d  = '0;
      for (int i = 0; i < NCH; i++) begin
         if (timer_q[i] != 32'd0) timer_d[i] = timer_q[i] - 32'd1;
         if (armed_q[i] && timer_q[i] == 32'd0) begin
            fire_d[i]  = 1'b1;
            armed_d[i] = 1'b0;
         end
      end
      if (match) begin
         timer_d[idx_q] = load_val;
         armed_d[idx_q] = 1'b1;
      end
      if (!synced) begin
         timer_d = '0;
         armed_d = '0;
         fire_d  = '0;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= ST_IDLE;
         prev_len_q <= '0;
         phase_q    <= '0;
         win_q      <= '0;
         div_q      <= '0;
         rem_q      <= '0;
         quo_q      <= '0;
         cnt_q      <= '0;
         idx_q      <= '0;
         overrun_q  <= 1'b0;
         timer_q    <= '0;
         armed_q    <= '0;
         fire_q     <= '0;
      end else begin
         state_q    <= state_d;
         prev_len_q <= prev_len_d;
         phase_q    <= phase_d;
         win_q      <= win_d;
         div_q      <= div_d;
         rem_q      <= rem_d;
         quo_q      <= quo_d;
         cnt_q      <= cnt_d;
         idx_q      <= idx_d;
         overrun_q  <= overrun_d;
         timer_q    <= timer_d;
         armed_q    <= armed_d;
         fire_q     <= fire_d;
      end
   end

   assign fire    = fire_q;
   assign armed   = armed_q;
   assign busy    = (state_q != ST_IDLE);
   assign overrun = overrun_q;

endmodule

// File: tb/tb_angle_event_sched.sv
// Bench for angle_event_sched: directed scenarios plus random teeth, checked against a
// cycle-numbered angle/time model with a fire scoreboard.
module tb_angle_event_sched;
   localparam int NCH = 4;
   localparam int CYC = 720;

   logic              clk, reset_n, trigger, synced;
   logic [15:0]       eng_phase, next_tooth_length_deg;
   logic [31:0]       tooth_period;
   logic [16*NCH-1:0] ch_angle;
   logic [NCH-1:0]    ch_enable, fire, armed;
   logic              busy, overrun;
   logic [15:0]       ang_tb [NCH];

   angle_event_sched #(.NCH(NCH), .CYCLE_DEG(CYC)) dut (
      .clk(clk), .reset_n(reset_n), .trigger(trigger), .synced(synced),
      .eng_phase(eng_phase), .tooth_period(tooth_period),
      .next_tooth_length_deg(next_tooth_length_deg), .ch_angle(ch_angle),
      .ch_enable(ch_enable), .fire(fire), .armed(armed), .busy(busy), .overrun(overrun));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always_comb begin
      ch_angle = '0;
      for (int i = 0; i < NCH; i++) ch_angle[16*i +: 16] = ang_tb[i];
   end

   typedef struct {int ch; longint e;} exp_t;
   typedef struct {longint e; int ch; int phase; int win; longint tpd;} scan_t;

   int     n_vec = 0, n_err = 0;
   longint edge_n = 0;
   exp_t   fq[$];
   scan_t  sq[$];
   int     prev_len_m = 0;
   longint busy_end = 0;
   longint ld_m [NCH];
   longint fe_m [NCH];
   bit     exp_ovr = 0;
   bit     was_busy;
   scan_t  s;
   int     off, mk;
   longint prod, lv, tpd;
   logic [NCH-1:0] exp_arm;

   task automatic report(input string name, input longint act, input longint exp);
      n_err++;
      if (n_err <= 30)
         $display("FAIL %s at edge %0d: got %0h expected %0h", name, edge_n, act, exp);
   endtask

   // Reference model: every trigger schedules channel i's window test at trigger edge + 33 + i
   always @(posedge clk) begin
      edge_n = edge_n + 1;
      if (!reset_n) begin
         fq.delete(); sq.delete();
         prev_len_m = 0; busy_end = 0; exp_ovr = 0;
         for (int c = 0; c < NCH; c++) begin ld_m[c] = -1; fe_m[c] = -1; end
      end else begin
         was_busy = (edge_n - 1 < busy_end);
         exp_ovr  = trigger && was_busy;
         if (!synced) begin
            sq.delete();
            busy_end = 0;
            for (int c = 0; c < NCH; c++) begin ld_m[c] = -1; fe_m[c] = -1; end
            for (int j = fq.size() - 1; j >= 0; j--) if (fq[j].e >= edge_n) fq.delete(j);
         end else if (!trigger) begin
            while (sq.size() > 0 && sq[0].e == edge_n) begin
               s = sq.pop_front();
               if (ch_enable[s.ch] && int'(ang_tb[s.ch]) < CYC && !(fe_m[s.ch] >= edge_n)) begin
                  off = (int'(ang_tb[s.ch]) - s.phase) % CYC;
                  if (off < 0) off += CYC;
                  if (off < s.win) begin
                     prod = longint'(off) * s.tpd;
                     lv   = (prod > 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : prod;
                     ld_m[s.ch] = edge_n;
                     fe_m[s.ch] = edge_n + lv + 1;
                     fq.push_back('{s.ch, edge_n + lv + 1});
                  end
               end
            end
         end
         if (trigger) begin
            sq.delete();
            busy_end = 0;
            if (synced && prev_len_m != 0 && next_tooth_length_deg != 0) begin
               tpd = longint'(tooth_period) / prev_len_m;
               for (int i = 0; i < NCH; i++)
                  sq.push_back('{edge_n + 33 + i, i, int'(eng_phase), int'(next_tooth_length_deg), tpd});
               busy_end = edge_n + 32 + NCH;
            end
            prev_len_m = int'(next_tooth_length_deg);
         end
      end
   end

   // Monitor: pops expected fires when the DUT pulses; per-cycle status checks
   always @(negedge clk) begin
      for (int c = 0; c < NCH; c++) begin
         if (fire[c]) begin
            mk = -1;
            for (int j = 0; j < fq.size(); j++)
               if (fq[j].ch == c && (mk < 0 || fq[j].e < fq[mk].e)) mk = j;
            n_vec++;
            if (mk < 0) report($sformatf("fire_unexpected_ch%0d", c), 1, 0);
            else begin
               if (fq[mk].e != edge_n) report($sformatf("fire_edge_ch%0d", c), edge_n, fq[mk].e);
               fq.delete(mk);
            end
         end
      end
      for (int j = fq.size() - 1; j >= 0; j--) begin
         if (fq[j].e < edge_n) begin
            n_vec++;
            report($sformatf("fire_missing_ch%0d", fq[j].ch), 0, fq[j].e);
            fq.delete(j);
         end
      end
      for (int c = 0; c < NCH; c++) exp_arm[c] = (ld_m[c] <= edge_n) && (edge_n < fe_m[c]);
      n_vec++; if (armed !== exp_arm) report("armed", longint'(armed), longint'(exp_arm));
      n_vec++; if (busy !== (edge_n < busy_end)) report("busy", longint'(busy), longint'(edge_n < busy_end));
      n_vec++; if (overrun !== exp_ovr) report("overrun", longint'(overrun), longint'(exp_ovr));
   end

   task automatic tick(input int k);
      repeat (k) @(negedge clk);
   endtask

   task automatic send_trig(input int ph, input logic [31:0] per, input int len);
      @(negedge clk);
      eng_phase = 16'(ph); tooth_period = per; next_tooth_length_deg = 16'(len);
      trigger = 1'b1;
      @(negedge clk);
      trigger = 1'b0;
   endtask

   task automatic set_ch(input int a0, input int a1, input int a2, input int a3, input logic [3:0] en);
      ang_tb[0] = 16'(a0); ang_tb[1] = 16'(a1); ang_tb[2] = 16'(a2); ang_tb[3] = 16'(a3);
      ch_enable = en;
   endtask

   initial begin
      reset_n = 1'b0; trigger = 1'b0; synced = 1'b0;
      eng_phase = '0; tooth_period = '0; next_tooth_length_deg = '0;
      set_ch(0, 0, 0, 0, 4'b0000);
      tick(3);
      n_vec++;
      if ({fire, armed, busy, overrun} !== '0) report("reset_outputs", longint'({fire, armed, busy, overrun}), 0);
      reset_n = 1'b1;
      synced  = 1'b1;

      // first synced trigger has no divisor; then div=10, tpd=100, ch0 offset 5, ch1 offset 10
      set_ch(105, 110, 3, 720, 4'b0011);
      send_trig(50, 1000, 10);
      tick(5);
      send_trig(100, 1000, 10);
      tick(600);

      // wrap-around: phase 715, ch2 at 3 -> offset 8; ch3 at 720 is out of range
      set_ch(105, 110, 3, 720, 4'b1100);
      send_trig(715, 1000, 10);
      tick(850);

      // saturation (div=1, huge period, offset 2) and zero offset on ch0
      set_ch(0, 2, 3, 720, 4'b0000);
      send_trig(300, 50, 1);
      tick(40);
      ch_enable = 4'b0011;
      send_trig(0, 32'hFFFF_FFFF, 10);
      tick(50);

      // sync loss cancels the saturated ch1 timer
      synced = 1'b0;
      tick(3);
      synced = 1'b1;
      tick(5);

      // overrun: ch0 armed, then two close triggers
      set_ch(105, 110, 3, 720, 4'b0001);
      send_trig(100, 1000, 10);
      tick(40);
      send_trig(100, 1000, 10);
      tick(10);
      send_trig(100, 1000, 10);
      tick(600);

      // asynchronous reset in the middle of a divide
      send_trig(100, 1000, 10);
      tick(5);
      #2 reset_n = 1'b0;
      #1;
      n_vec++;
      if ({fire, armed, busy, overrun} !== '0) report("async_reset", longint'({fire, armed, busy, overrun}), 0);
      tick(2);
      reset_n = 1'b1;
      tick(2);

      // random teeth
      for (int t = 0; t < 150; t++) begin
         for (int c = 0; c < NCH; c++) ang_tb[c] = 16'($urandom_range(0, 730));
         ch_enable = 4'($urandom);
         send_trig($urandom_range(0, CYC - 1), 32'($urandom_range(0, 200)),
                   ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 20));
         if ($urandom_range(0, 19) == 0) begin
            synced = 1'b0;
            tick($urandom_range(1, 3));
            synced = 1'b1;
         end
         tick($urandom_range(1, 70));
      end

      for (int k = 0; k < 6000; k++) begin
         if (fq.size() == 0) break;
         @(negedge clk);
      end
      if (fq.size() != 0) begin
         n_vec++;
         report("drain_timeout", fq.size(), 0);
      end
      tick(2);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
